// File: rtl/timer_bank.sv
// Bank of N_CH independent interval timers behind one word-addressed register port.
// Each channel has preset, power-of-two prescaler, one-shot/auto-reload/free-run modes and a W1C pending flag.
module timer_bank #(
  parameter int N_CH  = 2,
  parameter int WIDTH = 32,
  parameter int AW    = (N_CH <= 2) ? 3 : $clog2(N_CH) + 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   addr,
  input  logic            we,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic [N_CH-1:0] irq
);

  localparam int CW = AW - 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_PRESET = 2'd1,
    REG_COUNT  = 2'd2,
    REG_STATUS = 2'd3
  } reg_e;

  // Field order mirrors the CTRL bit layout so a cast maps wdata[7:0] directly.
  typedef struct packed {
    logic [3:0] ps;
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  logic [CW-1:0] ch_sel;
  reg_e          reg_sel;
  logic [31:0]   rd_ch [N_CH];

  assign ch_sel  = addr[AW-1:2];
  assign reg_sel = reg_e'(addr[1:0]);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    ctrl_t            ctrl_q, ctrl_d;
    logic [WIDTH-1:0] preset_q, preset_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             pend_q, pend_d;
    state_e           state_q, state_d;
    logic [14:0]      presc_q, presc_d;
    logic [14:0]      presc_top;
    logic [WIDTH-1:0] load_val;
    logic [31:0]      rd_val;
    logic             sel, tick, free_run, reload, set_pend;

    assign sel       = we && (ch_sel == CW'(c));
    assign presc_top = (15'd1 << ctrl_q.ps) - 15'd1;
    // >= rather than == so a PS decrease mid-count cannot strand the prescaler above its new top.
    assign tick      = (presc_q >= presc_top);
    assign free_run  = (ctrl_q.mode == 2'b10);
    assign reload    = (ctrl_q.mode == 2'b01);
    assign load_val  = (preset_q == '0) ? WIDTH'(1) : preset_q;

    always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
      ctrl_d   = ctrl_q;
      preset_d = preset_q;
      count_d  = count_q;
      state_d  = state_q;
      pend_d   = pend_q;
      presc_d  = '0;
      set_pend = 1'b0;

      case (state_q)
        ST_IDLE: if (ctrl_q.en) state_d = ST_LOAD;
        ST_LOAD: begin
          count_d = free_run ? '0 : load_val;
          state_d = ST_CNT;
        end
        ST_CNT: begin
          if (!ctrl_q.en) begin
            state_d = ST_IDLE;
          end else begin
            presc_d = tick ? '0 : presc_q + 15'd1;
            if (tick) begin
              if (free_run) begin
                count_d  = count_q + WIDTH'(1);
                set_pend = (count_q == '1);
              end else if (count_q > WIDTH'(1)) begin
                count_d = count_q - WIDTH'(1);
              end else begin
                count_d  = '0;
                set_pend = 1'b1;
                state_d  = ST_INT;
              end
            end
          end
        end
        ST_INT: begin
          // INT occupies one prescaled tick, keeping the reload period at (P+1) ticks.
          presc_d = tick ? '0 : presc_q + 15'd1;
          if (tick) begin
            if (reload) begin
              count_d = load_val;
              state_d = ST_CNT;
            end else begin
              ctrl_d.en = 1'b0;
              state_d   = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // Software writes come after the FSM so a CTRL write beats the one-shot EN clear.
      if (sel) begin
        case (reg_sel)
          REG_CTRL:   ctrl_d   = ctrl_t'(wdata[7:0]);
          REG_PRESET: preset_d = wdata[WIDTH-1:0];
          REG_STATUS: if (wdata[0]) pend_d = 1'b0;
          default:    ;
        endcase
      end
      if (set_pend) pend_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        ctrl_q   <= '0;
        preset_q <= '0;
        count_q  <= '0;
        pend_q   <= 1'b0;
        state_q  <= ST_IDLE;
        presc_q  <= '0;
      end else begin
        // NOTE: non-blocking assignments here so every flop samples the pre-edge value of its peers.
        ctrl_q   <= ctrl_d;
        preset_q <= preset_d;
        count_q  <= count_d;
        pend_q   <= pend_d;
        state_q  <= state_d;
        presc_q  <= presc_d;
      end
    end

    always_comb begin
      rd_val = '0;
      case (reg_sel)
        REG_CTRL:   rd_val = 32'(ctrl_q);
        REG_PRESET: rd_val = 32'(preset_q);
        REG_COUNT:  rd_val = 32'(count_q);
        REG_STATUS: rd_val = {29'd0, state_q, pend_q};
        default:    rd_val = '0;
      endcase
    end

    assign rd_ch[c] = rd_val;
    assign irq[c]   = pend_q & ctrl_q.im;
  end

  // Channel indices at or above N_CH match nothing and read as zero.
  always_comb begin
    rdata = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (ch_sel == CW'(c)) rdata = rd_ch[c];
    end
  end

endmodule
